mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the execute stage and the word-organised data memory. Accepts one byte/halfword/word access request at a time, drives the memory's word-wide read and write port, and returns a result. Sub-word stores become read-modify-write sequences, because the memory writes whole words only. Loads are lane-selected and sign- or zero-extended, and misaligned requests are rejected without touching memory.

## Interface
- No parameters; data and address width fixed at 32 bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_width`  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
- `req_signed`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low 8/16/32 bits are used.
- `req_pc`  in  32  PC of the issuing instruction; passed to memory for trace.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal request; valid with `resp_valid`.
- `mem_write_enable`  out  1  word write strobe to memory.
- `mem_addr`  out  32  word-aligned address {addr[31:2],2'b00}.
- `mem_write`  out  32  full word to write.
- `mem_read`  in  32  combinational read data of `mem_addr`.
- `mem_pc`  out  32  captured `req_pc`.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. Address, data, width, signed, write and pc are captured into registers at acceptance.
- States: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1.
  - Accepted request → RESP with error if misaligned.
  - Accepted load or sub-word store → RD.
  - Accepted word store → WR.
- RD: `mem_addr` driven and `mem_read` captured at the edge.
  - Load → RESP.
  - Sub-word store → WR.
- WR: `mem_write_enable`=1 for exactly this cycle → RESP.
  - Word store: `mem_write` = wdata.
  - Sub-word store: `mem_write` = captured word with the target lanes replaced.
- RESP: `resp_valid`=1 for one cycle → IDLE.
- Misaligned cases:
  - width 01 with addr[0]=1.
  - width 00 with addr[1:0]≠0.
  - width 11 with any address.
- Lane rules (little-endian): byte lane k = bits [8k+7:8k], k = addr[1:0]. Halfword uses lanes {1,0} if addr[1]=0, else lanes {3,2}. Replaced lanes take wdata[7:0] or wdata[15:0].
- Load result: the selected byte/half moves to bit 0 and is extended per `req_signed`. A word load is returned unchanged.
- Error response: no memory access, `resp_err`=1, `resp_rdata`=0.
- `mem_addr`, `mem_write` and `mem_pc` hold their captured values from acceptance until IDLE, and are 0 in IDLE.

## Timing
- Reset values: state IDLE; `req_ready`=1; every other output and capture register 0.
- Latency, counted from the accept edge (edge 0) to the edge ending the `resp_valid` cycle:
  - load: 3 edges (RD, RESP).
  - word store: 3 edges (WR, RESP).
  - sub-word store: 4 edges (RD, WR, RESP).
  - error: 2 edges (RESP).
- `req_ready` is 0 from the cycle after acceptance through RESP. A new request is accepted in the cycle after RESP at the earliest, so back-to-back throughput is one request per latency.
- `resp_rdata` and `resp_err` are registered and valid only while `resp_valid`=1; they return to 0 afterward.
- Reset asserted mid-operation drops `mem_write_enable` combinationally and aborts. If reset is low across the WR edge, no write occurs. No response is produced for the aborted request.
- `req_valid` while `req_ready`=0 is ignored; the requester holds it.

## Test plan
- Word load: memory word 0x10 = 0x8899AABB; load width 00 at 0x10 → RD cycle has `mem_addr`=0x10; RESP `resp_rdata`=0x8899AABB, `resp_err`=0.
- Signed/unsigned byte load: same word; byte at 0x13 signed → 0xFFFFFF88; unsigned → 0x00000088; half at 0x12 signed → 0xFFFF8899.
- Byte store RMW: word 0x20 = 0x11223344; store byte 0xAB at 0x21 → WR cycle `mem_write`=0x1122AB44 with `mem_write_enable` high exactly one cycle; RESP 4 edges after accept.
- Halfword and word store: half 0xBEEF at 0x22 over 0x11223344 → 0xBEEF3344; word 0xDEADBEEF at 0x24 → written in WR, latency 3.
- Misaligned: load half at 0x31; store word at 0x32; width 11 → `resp_err`=1 and `resp_rdata`=0 two edges after accept; `mem_write_enable` never asserted.
- Reset mid-RMW: assert reset low during RD of a byte store → memory unchanged; outputs at reset values; `req_ready`=1 after release. Then two back-to-back loads are accepted in consecutive IDLE windows.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute stage and a word-wide data memory.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write,
  input  logic [31:0] mem_read,
  output logic [31:0] mem_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    W_WORD = 2'b00,
    W_HALF = 2'b01,
    W_BYTE = 2'b10,
    W_ILL  = 2'b11
  } width_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  width_e      width_q, width_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] wword_q, wword_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  function automatic logic misaligned(input width_e w, input logic [1:0] lo);
    logic bad;
    case (w)
      W_WORD:  bad = (lo != 2'b00);
      W_HALF:  bad = lo[0];
      W_BYTE:  bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input width_e      w,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (w)
      W_BYTE:  r = {{24{sgn & b[7]}}, b};
      W_HALF:  r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  lo,
                                              input width_e      w);
    logic [31:0] r;
    r = word;
    case (w)
      W_BYTE: r[{lo, 3'b000} +: 8] = data[7:0];
      W_HALF: begin
        if (lo[1]) r[31:16] = data[15:0];
        else       r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      width_q  <= W_WORD;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      pc_q     <= '0;
      wword_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      pc_q     <= pc_d;
      wword_q  <= wword_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Response registers default to 0 so they are only non-zero during RESP.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    width_d  = width_q;
    signed_d = signed_q;
    write_d  = write_q;
    pc_d     = pc_q;
    wword_d  = wword_q;
    rdata_d  = '0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          width_d  = width_e'(req_width);
          signed_d = req_signed;
          write_d  = req_write;
          pc_d     = req_pc;
          wword_d  = req_wdata;
          if (misaligned(width_e'(req_width), req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_write && (width_e'(req_width) == W_WORD)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (write_q) begin
          wword_d = store_merge(mem_read, wword_q, addr_q[1:0], width_q);
          state_d = S_WR;
        end else begin
          rdata_d = load_extract(mem_read, addr_q[1:0], width_q, signed_q);
          state_d = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      default: begin
        addr_d   = '0;
        width_d  = W_WORD;
        signed_d = 1'b0;
        write_d  = 1'b0;
        pc_d     = '0;
        wword_d  = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = (state_q == S_RESP);
  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign mem_write_enable = (state_q == S_WR) && reset;
  assign mem_addr         = {addr_q[31:2], 2'b00};
  assign mem_write        = wword_q;
  assign mem_pc           = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-addressed memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_write;
  logic [31:0] mem_read;
  logic [31:0] mem_pc;

  logic [31:0] mem [0:63];
  int unsigned errors;
  int unsigned checks;

  mem_access_unit dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_width        (req_width),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_pc           (req_pc),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_write        (mem_write),
    .mem_read         (mem_read),
    .mem_pc           (mem_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr[7:2]] <= mem_write;
  end

  // Issues one request and observes it to completion; no checking here.
  task automatic run_req(input logic wr, input logic [1:0] w, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int we_cnt, output logic [31:0] wword,
                         output logic [31:0] addr0, output logic [31:0] pc0,
                         output logic rdy0, output logic tmo);
    logic saw;
    int edges;
    saw = 1'b0; edges = 0; we_cnt = 0; wword = '0; rd = '0; er = 1'b0;
    addr0 = '0; pc0 = '0; rdy0 = 1'b1; tmo = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_width = w; req_signed = sg;
    req_addr = a; req_wdata = wd; req_pc = pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk);
      if (i == 0) begin
        addr0 = mem_addr; pc0 = mem_pc; rdy0 = req_ready;
      end
      if (mem_write_enable) begin
        we_cnt++; wword = mem_write;
      end
      if (resp_valid) begin
        saw = 1'b1; rd = resp_rdata; er = resp_err;
      end
      @(posedge clk);
      edges++;
    end
    lat = edges + 1;
    tmo = !saw;
  endtask

  int          lat, wec;
  logic [31:0] rd, ww, a0, p0;
  logic        er, r0, tmo;

  task automatic test_reset;
    reset = 1'b0;
    #12;
    checks++;
    if ({req_ready, resp_valid, mem_write_enable, resp_err} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, resp_valid, mem_write_enable, resp_err});
    end
    checks++;
    if ({mem_addr, mem_write, mem_pc, resp_rdata} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0", mem_addr, mem_write, mem_pc, resp_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word_load;
    run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h400, lat, rd, er, wec, ww, a0, p0, r0, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL wload_timeout: got %b expected 0", tmo); end
    checks++;
    if (a0 !== 32'h10) begin errors++; $display("FAIL wload_addr: got %h expected 00000010", a0); end
    checks++;
    if (p0 !== 32'h400) begin errors++; $display("FAIL wload_pc: got %h expected 00000400", p0); end
    checks++;
    if (r0 !== 1'b0) begin errors++; $display("FAIL wload_ready_low: got %b expected 0", r0); end
    checks++;
    if ({rd, er} !== {32'h8899AABB, 1'b0}) begin
      errors++; $display("FAIL wload_data: got %h err %b expected 8899aabb err 0", rd, er);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wload_latency: got %0d expected 3", lat); end
    checks++;
    if (wec !== 0) begin errors++; $display("FAIL wload_we: got %0d expected 0", wec); end
  endtask

  task automatic test_subword_load;
    logic [31:0] addrs [5];
    logic [1:0]  wids  [5];
    logic        sgns  [5];
    logic [31:0] exps  [5];
    addrs = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11};
    wids  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
    sgns  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exps  = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'hFFFFFFAA};
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, wids[i], sgns[i], addrs[i], 32'h0, 32'h500, lat, rd, er, wec, ww, a0, p0, r0, tmo);
      checks++;
      if ({rd, er, lat} !== {exps[i], 1'b0, 32'd3}) begin
        errors++; $display("FAIL subload_%0d: got %h err %b lat %0d expected %h err 0 lat 3", i, rd, er, lat, exps[i]);
      end
    end
  endtask

  task automatic test_byte_store;
    mem[8] = 32'h11223344;
    run_req(1'b1, 2'b10, 1'b0, 32'h21, 32'hFFFFFFAB, 32'h600, lat, rd, er, wec, ww, a0, p0, r0, tmo);
    checks++;
    if (wec !== 1) begin errors++; $display("FAIL bstore_we_cycles: got %0d expected 1", wec); end
    checks++;
    if (ww !== 32'h1122AB44) begin errors++; $display("FAIL bstore_wword: got %h expected 1122ab44", ww); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bstore_latency: got %0d expected 4", lat); end
    checks++;
    if ({rd, er} !== 33'd0) begin errors++; $display("FAIL bstore_resp: got %h err %b expected 0 err 0", rd, er); end
    checks++;
    if (mem[8] !== 32'h1122AB44) begin errors++; $display("FAIL bstore_mem: got %h expected 1122ab44", mem[8]); end
  endtask

  task automatic test_half_word_store;
    mem[8] = 32'h11223344;
    run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 32'h700, lat, rd, er, wec, ww, a0, p0, r0, tmo);
    checks++;
    if ({ww, wec, lat} !== {32'hBEEF3344, 32'd1, 32'd4}) begin
      errors++; $display("FAIL hstore: got %h we %0d lat %0d expected beef3344 we 1 lat 4", ww, wec, lat);
    end
    checks++;
    if (mem[8] !== 32'hBEEF3344) begin errors++; $display("FAIL hstore_mem: got %h expected beef3344", mem[8]); end
    mem[9] = 32'h0;
    run_req(1'b1, 2'b00, 1'b0, 32'h24, 32'hDEADBEEF, 32'h704, lat, rd, er, wec, ww, a0, p0, r0, tmo);
    checks++;
    if ({ww, wec, lat} !== {32'hDEADBEEF, 32'd1, 32'd3}) begin
      errors++; $display("FAIL wstore: got %h we %0d lat %0d expected deadbeef we 1 lat 3", ww, wec, lat);
    end
    checks++;
    if (mem[9] !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore_mem: got %h expected deadbeef", mem[9]); end
  endtask

  task automatic test_misaligned;
    logic        wrs  [3];
    logic [1:0]  wids [3];
    logic [31:0] addrs[3];
    wrs   = '{1'b0, 1'b1, 1'b1};
    wids  = '{2'b01, 2'b00, 2'b11};
    addrs = '{32'h31, 32'h32, 32'h30};
    mem[12] = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      run_req(wrs[i], wids[i], 1'b1, addrs[i], 32'h55667788, 32'h800, lat, rd, er, wec, ww, a0, p0, r0, tmo);
      checks++;
      if ({er, rd, lat, wec} !== {1'b1, 32'd0, 32'd2, 32'd0}) begin
        errors++; $display("FAIL misalign_%0d: got err %b rd %h lat %0d we %0d expected err 1 rd 0 lat 2 we 0", i, er, rd, lat, wec);
      end
    end
    checks++;
    if (mem[12] !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_mem: got %h expected cafef00d", mem[12]); end
  endtask

  task automatic test_reset_mid_rmw;
    int rv, we;
    rv = 0; we = 0;
    mem[8] = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_width = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h000000AB; req_pc = 32'h900;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h20) begin errors++; $display("FAIL rst_rd_addr: got %h expected 00000020", mem_addr); end
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mem_write_enable, resp_err, mem_addr, mem_write, mem_pc} !== {4'b1000, 96'd0}) begin
      errors++; $display("FAIL rst_abort_outputs: got rdy %b rv %b we %b err %b addr %h wr %h pc %h expected 1 0 0 0 and zeros",
                         req_ready, resp_valid, mem_write_enable, resp_err, mem_addr, mem_write, mem_pc);
    end
    repeat (2) begin
      @(negedge clk);
      if (mem_write_enable) we++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) rv++;
      if (mem_write_enable) we++;
    end
    checks++;
    if ({rv, we} !== 64'd0) begin errors++; $display("FAIL rst_no_resp_write: got rv %0d we %0d expected 0 0", rv, we); end
    checks++;
    if (mem[8] !== 32'h11223344) begin errors++; $display("FAIL rst_mem: got %h expected 11223344", mem[8]); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_back_to_back;
    time t1, t2;
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA00, lat, rd, er, wec, ww, a0, p0, r0, tmo);
    t1 = $time;
    checks++;
    if ({rd, er, tmo} !== {32'h000000BB, 2'b00}) begin errors++; $display("FAIL b2b_first: got %h err %b tmo %b expected 000000bb 0 0", rd, er, tmo); end
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hA04, lat, rd, er, wec, ww, a0, p0, r0, tmo);
    t2 = $time;
    checks++;
    if ({rd, er, tmo} !== {32'hFFFF8899, 2'b00}) begin errors++; $display("FAIL b2b_second: got %h err %b tmo %b expected ffff8899 0 0", rd, er, tmo); end
    checks++;
    if (t2 - t1 !== 30) begin errors++; $display("FAIL b2b_spacing: got %0t expected 30", t2 - t1); end
  endtask

  initial begin
    errors = 0; checks = 0;
    req_valid = 1'b0; req_write = 1'b0; req_width = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    test_reset;
    test_word_load;
    test_subword_load;
    test_byte_store;
    test_half_word_store;
    test_misaligned;
    test_reset_mid_rmw;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
